regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised register file with two registered read ports and one write port, built around the indexed word-select function of the existing 16-way 32-bit read multiplexer.
- Adds storage, a one-cycle registered read with valid strobe, write-first bypass, optional hardwired zero register and out-of-range detection.
- Sits between instruction decode and the ALU in the datapath.
- Also exposes a flat snapshot of all registers for debug/display.

Parameters:
- WIDTH, 32: bits per register.
- DEPTH, 16: number of registers, 2..32.
- ADDR_W, 5: address width; DEPTH must be <= 2**ADDR_W.
- ZERO_REG, 0: when 1, register 0 always reads 0 and writes to it are ignored.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- re_a  input  1  read request, port A.
- raddr_a  input  ADDR_W  read address, port A.
- rdata_a  output  WIDTH  registered read data, port A.
- rvalid_a  output  1  one-cycle strobe, rdata_a updated.
- rerr_a  output  1  accompanies rvalid_a; address was out of range.
- re_b, raddr_b, rdata_b, rvalid_b, rerr_b: identical to port A, for port B.
- snapshot  output  WIDTH*DEPTH  combinational image of storage; register 0 in the most significant WIDTH bits, register DEPTH-1 in the least significant.

Behaviour:
- Reset
  - One clock; reset is asynchronous and active-high.
  - While rst is high: all registers, rdata_a/b, rvalid_a/b and rerr_a/b are 0, and snapshot is 0.
  - Reset asserted mid-operation discards any pending read strobe and any write in that cycle.
- Write
  - Occurs on the posedge when we=1 and waddr<DEPTH, and not (ZERO_REG=1 and waddr=0).
  - Otherwise the write is silently dropped; no error flag.
- Read
  - Latency 1: a request (re_x=1) sampled at posedge N produces rdata_x and rvalid_x=1 after posedge N; rvalid_x is high for exactly one cycle per request.
  - Back-to-back requests on consecutive cycles give consecutive strobes; throughput is 1 read per port per cycle.
  - When re_x=0 at a posedge: rvalid_x and rerr_x go to 0, and rdata_x holds its previous value.
  - Ports A and B are fully independent and may read the same address in the same cycle.
- Bypass (write-first)
  - If a read and an accepted write target the same address on the same posedge, rdata_x returns wdata, not the old contents.
  - A dropped write (out of range, or zero register) never bypasses.
- Out of range
  - raddr_x >= DEPTH: rdata_x=0, rerr_x=1, rvalid_x=1.
- Zero register
  - With ZERO_REG=1, a read of address 0 returns 0, rerr=0.
- Snapshot
  - Reflects storage after the clock edge; it does not show the bypass.
  - With ZERO_REG=1, its register-0 slice is 0.
- Arithmetic
  - No arithmetic; address compare is unsigned at ADDR_W bits.

Test Plan:
- Reset values: assert rst mid-run with prior writes -> all outputs 0 immediately (asynchronous); deassert, read r3 -> rdata=0, rvalid=1 one cycle after the request.
- Basic write/read: write r5=0xDEADBEEF, next cycle re_a with raddr_a=5 -> rdata_a=0xDEADBEEF one cycle later, rvalid_a pulse width 1, rerr_a=0; snapshot bits [351:320]=0xDEADBEEF with defaults.
- Bypass: same cycle we=1, waddr=7, wdata=0x12345678, re_a and re_b both at addr 7 (r7 previously 0x1) -> both ports return 0x12345678.
- Out of range (DEPTH=16): raddr_b=20 -> rdata_b=0, rerr_b=1, rvalid_b=1; write to waddr=17 leaves snapshot unchanged.
- ZERO_REG=1: write r0=0xFFFFFFFF, then read r0 -> 0, rerr=0; snapshot top 32 bits = 0; same-cycle write/read of r0 also returns 0.
- Streaming: re_a held high for 16 cycles sweeping addresses 0..15 after preloading reg i with i*3 -> 16 consecutive rvalid_a cycles with rdata_a = 0,3,...,45; then re_a=0 -> rvalid_a=0 and rdata_a stays 45.

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w
//   Register file with one write port and two independent registered read
//   ports. Reads have a latency of one clock, return the data being written
//   on the same edge (write-first bypass), and flag addresses at or beyond
//   DEPTH. Register 0 can optionally be hardwired to zero. All storage is
//   also exposed as a flat combinational snapshot for debug.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset
//   we/waddr/wdata      write port
//   re_x/raddr_x        read request and address, x = a, b
//   rdata_x             registered read data (holds when no request)
//   rvalid_x            one-cycle strobe per accepted request
//   rerr_x              set with rvalid_x when the address was out of range
//   snapshot            register 0 in the MSBs, register DEPTH-1 in the LSBs
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   re_a,
  input  logic [ADDR_W-1:0]      raddr_a,
  output logic [WIDTH-1:0]       rdata_a,
  output logic                   rvalid_a,
  output logic                   rerr_a,
  input  logic                   re_b,
  input  logic [ADDR_W-1:0]      raddr_b,
  output logic [WIDTH-1:0]       rdata_b,
  output logic                   rvalid_b,
  output logic                   rerr_b,
  output logic [WIDTH*DEPTH-1:0] snapshot
);

  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] word_a_p0, word_b_p0;
  logic             oor_a_p0, oor_b_p0;

  logic [WIDTH-1:0] rdata_a_p1, rdata_b_p1;
  logic             vld_a_p1, vld_b_p1;
  logic             err_a_p1, err_b_p1;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_C);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // ---- stage p0: write qualification, word select and bypass ----
  assign wr_ok = we && in_range(waddr) && !is_zero_reg(waddr);

  always_comb begin
    word_a_p0 = '0;
    word_b_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) word_a_p0 = mem[i];
      if (raddr_b == ADDR_W'(i)) word_b_p0 = mem[i];
    end
    // wr_ok already excludes dropped writes, so they never bypass.
    if (wr_ok && (waddr == raddr_a)) word_a_p0 = wdata;
    if (wr_ok && (waddr == raddr_b)) word_b_p0 = wdata;
    if (!in_range(raddr_a) || is_zero_reg(raddr_a)) word_a_p0 = '0;
    if (!in_range(raddr_b) || is_zero_reg(raddr_b)) word_b_p0 = '0;
  end

  assign oor_a_p0 = !in_range(raddr_a);
  assign oor_b_p0 = !in_range(raddr_b);

  // Storage. With ZERO_REG set, entry 0 is never written and stays at its
  // reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) mem[i] <= wdata;
      end
    end
  end

  // ---- stage p1: registered read outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a_p1 <= '0;
      vld_a_p1   <= 1'b0;
      err_a_p1   <= 1'b0;
      rdata_b_p1 <= '0;
      vld_b_p1   <= 1'b0;
      err_b_p1   <= 1'b0;
    end else begin
      vld_a_p1 <= re_a;
      err_a_p1 <= re_a && oor_a_p0;
      if (re_a) rdata_a_p1 <= word_a_p0;
      vld_b_p1 <= re_b;
      err_b_p1 <= re_b && oor_b_p0;
      if (re_b) rdata_b_p1 <= word_b_p0;
    end
  end

  assign rdata_a  = rdata_a_p1;
  assign rvalid_a = vld_a_p1;
  assign rerr_a   = err_a_p1;
  assign rdata_b  = rdata_b_p1;
  assign rvalid_b = vld_b_p1;
  assign rerr_b   = err_b_p1;

  for (genvar g = 0; g < DEPTH; g++) begin : g_snap
    assign snapshot[WIDTH*(DEPTH-g)-1 -: WIDTH] = mem[g];
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: two instances share all inputs, one with the
// default parameters and one with ZERO_REG=1, both checked against an
// array-based reference model.
module tb_regfile_2r1w;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          we, re_a, re_b;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [W-1:0]  wdata;

  logic [W-1:0]   rd_a [2];
  logic [W-1:0]   rd_b [2];
  logic           rv_a [2];
  logic           rv_b [2];
  logic           er_a [2];
  logic           er_b [2];
  logic [W*D-1:0] snap [2];

  regfile_2r1w #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .ZERO_REG(0)) u0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rd_a[0]), .rvalid_a(rv_a[0]), .rerr_a(er_a[0]),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rd_b[0]), .rvalid_b(rv_b[0]), .rerr_b(er_b[0]),
    .snapshot(snap[0]));

  regfile_2r1w #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .ZERO_REG(1)) u1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rd_a[1]), .rvalid_a(rv_a[1]), .rerr_a(er_a[1]),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rd_b[1]), .rvalid_b(rv_b[1]), .rerr_b(er_b[1]),
    .snapshot(snap[1]));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: register contents and expected outputs per instance.
  logic [W-1:0] m [2][D];
  logic [W-1:0] ed_a [2];
  logic [W-1:0] ed_b [2];
  logic         ev_a [2];
  logic         ev_b [2];
  logic         ee_a [2];
  logic         ee_b [2];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < D; i++) m[k][i] = '0;
      ed_a[k] = '0; ed_b[k] = '0;
      ev_a[k] = 1'b0; ev_b[k] = 1'b0;
      ee_a[k] = 1'b0; ee_b[k] = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] ref_read(input int k, input int addr, input logic ok,
                                            input int wa, input logic [W-1:0] wd);
    if (addr >= D) return '0;
    if (k == 1 && addr == 0) return '0;
    if (ok && wa == addr) return wd;
    return m[k][addr];
  endfunction

  function automatic logic [W*D-1:0] exp_snap(input int k);
    logic [W*D-1:0] s;
    for (int i = 0; i < D; i++) s[W*(D-i)-1 -: W] = m[k][i];
    return s;
  endfunction

  // Called right after a rising edge with the inputs that were sampled on it.
  task automatic model_edge();
    int   wa, aa, ab;
    logic ok;
    wa = int'(waddr); aa = int'(raddr_a); ab = int'(raddr_b);
    for (int k = 0; k < 2; k++) begin
      ok = we && (wa < D) && !(k == 1 && wa == 0);
      ev_a[k] = re_a; ee_a[k] = re_a && (aa >= D);
      if (re_a) ed_a[k] = ref_read(k, aa, ok, wa, wdata);
      ev_b[k] = re_b; ee_b[k] = re_b && (ab >= D);
      if (re_b) ed_b[k] = ref_read(k, ab, ok, wa, wdata);
      if (ok) m[k][wa] = wdata;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/u%0d/rdata_a", tag, k), 512'(rd_a[k]), 512'(ed_a[k]));
      chk($sformatf("%s/u%0d/rvalid_a", tag, k), 512'(rv_a[k]), 512'(ev_a[k]));
      chk($sformatf("%s/u%0d/rerr_a", tag, k), 512'(er_a[k]), 512'(ee_a[k]));
      chk($sformatf("%s/u%0d/rdata_b", tag, k), 512'(rd_b[k]), 512'(ed_b[k]));
      chk($sformatf("%s/u%0d/rvalid_b", tag, k), 512'(rv_b[k]), 512'(ev_b[k]));
      chk($sformatf("%s/u%0d/rerr_b", tag, k), 512'(er_b[k]), 512'(ee_b[k]));
      chk($sformatf("%s/u%0d/snapshot", tag, k), 512'(snap[k]), 512'(exp_snap(k)));
    end
  endtask

  task automatic step(input logic w, input int wa, input logic [W-1:0] wd,
                      input logic ra_en, input int ra, input logic rb_en, input int rb,
                      input string tag);
    we = w; waddr = AW'(wa); wdata = wd;
    re_a = ra_en; raddr_a = AW'(ra);
    re_b = rb_en; raddr_b = AW'(rb);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    waddr = '0; raddr_a = '0; raddr_b = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // basic write then read
    step(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 0, "wr5");
    chk("snap_r5_slice", 512'(snap[0][351:320]), 512'(32'hDEADBEEF));
    step(1'b0, 0, '0, 1'b1, 5, 1'b0, 0, "rd5");
    chk("rd5_value", 512'(rd_a[0]), 512'(32'hDEADBEEF));
    step(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, "rd5_pulse_end");
    chk("rd5_pulse_width", 512'(rv_a[0]), 512'(1'b0));

    // write-first bypass on both ports
    step(1'b1, 7, 32'h1, 1'b0, 0, 1'b0, 0, "wr7");
    step(1'b1, 7, 32'h12345678, 1'b1, 7, 1'b1, 7, "bypass");
    chk("bypass_a", 512'(rd_a[0]), 512'(32'h12345678));
    chk("bypass_b", 512'(rd_b[0]), 512'(32'h12345678));

    // out of range read and write
    step(1'b0, 0, '0, 1'b0, 0, 1'b1, 20, "oor_rd");
    chk("oor_rerr_b", 512'(er_b[0]), 512'(1'b1));
    step(1'b1, 17, 32'hA5A5A5A5, 1'b0, 0, 1'b0, 0, "oor_wr");

    // zero register behaviour (u1) versus ordinary r0 (u0)
    step(1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 0, "wr_r0");
    chk("zr_snap_top", 512'(snap[1][511:480]), 512'(32'h0));
    step(1'b0, 0, '0, 1'b1, 0, 1'b1, 0, "rd_r0");
    chk("zr_rd_r0", 512'(rd_a[1]), 512'(32'h0));
    chk("r0_plain", 512'(rd_a[0]), 512'(32'hFFFFFFFF));
    step(1'b1, 0, 32'h12, 1'b1, 0, 1'b1, 0, "wrrd_r0");
    chk("zr_wrrd_r0", 512'(rd_b[1]), 512'(32'h0));

    // streaming sweep
    for (int i = 0; i < D; i++) step(1'b1, i, W'(i * 3), 1'b0, 0, 1'b0, 0, "preload");
    for (int i = 0; i < D; i++) begin
      step(1'b0, 0, '0, 1'b1, i, 1'b0, 0, "stream");
      chk($sformatf("stream_val%0d", i), 512'(rd_a[1]), 512'(W'(i * 3)));
      chk($sformatf("stream_vld%0d", i), 512'(rv_a[1]), 512'(1'b1));
    end
    step(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, "stream_stop");
    chk("stream_hold", 512'(rd_a[0]), 512'(32'd45));

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), W'($urandom),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), "random");
    end

    // asynchronous reset in mid-run; the write and reads pending now are discarded
    step(1'b1, 3, 32'hCAFEF00D, 1'b1, 3, 1'b1, 3, "pre_rst");
    we = 1'b1; waddr = AW'(4); wdata = 32'h55AA55AA;
    re_a = 1'b1; raddr_a = AW'(3); re_b = 1'b1; raddr_b = AW'(4);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b0;
    step(1'b0, 0, '0, 1'b1, 3, 1'b1, 4, "rd_after_rst");
    chk("rd3_after_rst", 512'(rd_a[0]), 512'(32'h0));
    chk("rv_after_rst", 512'(rv_a[0]), 512'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
